// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : which processor port owns the current transaction
//   req_attr_t  : latched attributes of the transaction being issued
//   pick_owner  : round-robin choice between pending ports
package mem_port_arbiter_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned MASK_WIDTH  = 4;
    localparam int unsigned TIMER_WIDTH = 8;

    localparam logic [MASK_WIDTH-1:0] MASK_ALL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e                owner;
        logic                  wr;
        logic [MASK_WIDTH-1:0] mask;
        logic [DATA_WIDTH-1:0] wdata;
    } req_attr_t;

    // Under contention the port that did not own the previous transaction wins.
    function automatic owner_e pick_owner(input logic inst_pend, input logic data_pend,
                                          input owner_e last_owner);
        if (inst_pend && data_pend) begin
            return (last_owner == OWN_INST) ? OWN_DATA : OWN_INST;
        end
        return data_pend ? OWN_DATA : OWN_INST;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Transaction wait timer for the memory port arbiter.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : restart the count (transaction is being issued)
//   en         : count this cycle (transaction in flight)
//   expired_c  : this enabled cycle is the MAX_WAIT-th since clr
module mem_port_arbiter_wait_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
)(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    // count holds the number of enabled cycles already completed, so the
    // cycle where it equals MAX_WAIT-1 is the last one allowed.
    localparam logic [TIMER_WIDTH-1:0] LAST = TIMER_WIDTH'(MAX_WAIT - 1);

    logic [TIMER_WIDTH-1:0] count;

    // Saturating cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + TIMER_WIDTH'(1);
        end
    end

    // >= so that a gnt that beats the limit in ISSUE still leaves WAIT bounded.
    assign expired_c = en && (count >= LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch and data ports.
// One transaction in flight at a time, round-robin under contention, with an
// abort after MAX_WAIT cycles spent issuing/waiting.
//   clk, reset              : clock, asynchronous active-low reset
//   ip_inst_req/addr        : fetch request (held until op_inst_valid)
//   op_inst_valid/from_mem  : fetch response pulse and data
//   ip_data_rd/wr/addr/mask/from_proc : data request (held until op_data_valid)
//   op_data_valid/from_mem  : data response pulse and read data (0 for writes)
//   op_mem_req/wr/addr/mask/wdata, ip_mem_gnt : memory request handshake
//   ip_mem_rvalid/rdata     : memory read return
//   op_timeout              : sticky abort flag
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 255
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ip_inst_req,
    input  logic [ADDR_WIDTH-1:0] ip_inst_addr,
    output logic                  op_inst_valid,
    output logic [DATA_WIDTH-1:0] op_inst_from_mem,
    input  logic                  ip_data_rd,
    input  logic                  ip_data_wr,
    input  logic [ADDR_WIDTH-1:0] ip_data_addr,
    input  logic [MASK_WIDTH-1:0] ip_data_mask,
    input  logic [DATA_WIDTH-1:0] ip_data_from_proc,
    output logic                  op_data_valid,
    output logic [DATA_WIDTH-1:0] op_data_from_mem,
    output logic                  op_mem_req,
    output logic                  op_mem_wr,
    output logic [ADDR_WIDTH-1:0] op_mem_addr,
    output logic [MASK_WIDTH-1:0] op_mem_mask,
    output logic [DATA_WIDTH-1:0] op_mem_wdata,
    input  logic                  ip_mem_gnt,
    input  logic                  ip_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] ip_mem_rdata,
    output logic                  op_timeout
);

    arb_state_e            state_q, state_d;
    req_attr_t             attr_q, attr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  mem_req_q, mem_req_d;
    logic                  inst_valid_q, inst_valid_d;
    logic                  data_valid_q, data_valid_d;
    logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
    logic                  timeout_q, timeout_d;
    owner_e                last_owner_q, last_owner_d;

    logic                  inst_pend_c;
    logic                  data_pend_c;
    owner_e                winner_c;
    logic                  timer_clr_c;
    logic                  timer_en_c;
    logic                  expired_c;
    logic                  resp_en_c;
    logic [DATA_WIDTH-1:0] resp_data_c;

    assign inst_pend_c = ip_inst_req;
    assign data_pend_c = ip_data_rd | ip_data_wr;
    assign winner_c    = pick_owner(inst_pend_c, data_pend_c, last_owner_q);
    assign timer_en_c  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

    mem_port_arbiter_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (timer_clr_c),
        .en        (timer_en_c),
        .expired_c (expired_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            attr_q       <= '0;
            addr_q       <= '0;
            mem_req_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            data_valid_q <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            timeout_q    <= 1'b0;
            last_owner_q <= OWN_INST;
        end else begin
            state_q      <= state_d;
            attr_q       <= attr_d;
            addr_q       <= addr_d;
            mem_req_q    <= mem_req_d;
            inst_valid_q <= inst_valid_d;
            data_valid_q <= data_valid_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            timeout_q    <= timeout_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        attr_d       = attr_q;
        addr_d       = addr_q;
        mem_req_d    = mem_req_q;
        inst_valid_d = 1'b0;
        data_valid_d = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        timeout_d    = timeout_q;
        last_owner_d = last_owner_q;
        timer_clr_c  = 1'b0;
        resp_en_c    = 1'b0;
        resp_data_c  = '0;

        case (state_q)
            ST_IDLE: begin
                if (inst_pend_c || data_pend_c) begin
                    attr_d.owner = winner_c;
                    if (winner_c == OWN_DATA) begin
                        // rd and wr together resolve to a write.
                        addr_d       = ip_data_addr;
                        attr_d.wr    = ip_data_wr;
                        attr_d.mask  = ip_data_wr ? ip_data_mask : MASK_ALL;
                        attr_d.wdata = ip_data_wr ? ip_data_from_proc : '0;
                    end else begin
                        addr_d       = ip_inst_addr;
                        attr_d.wr    = 1'b0;
                        attr_d.mask  = MASK_ALL;
                        attr_d.wdata = '0;
                    end
                    mem_req_d   = 1'b1;
                    timer_clr_c = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // A grant in the expiry cycle takes priority over the abort.
                if (ip_mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (attr_q.wr) begin
                        resp_en_c = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        state_d   = ST_WAIT;
                    end
                end else if (expired_c) begin
                    mem_req_d = 1'b0;
                    timeout_d = 1'b1;
                    resp_en_c = 1'b1;
                    state_d   = ST_RESP;
                end
            end

            ST_WAIT: begin
                if (ip_mem_rvalid) begin
                    resp_en_c   = 1'b1;
                    resp_data_c = ip_mem_rdata;
                    state_d     = ST_RESP;
                end else if (expired_c) begin
                    timeout_d = 1'b1;
                    resp_en_c = 1'b1;
                    state_d   = ST_RESP;
                end
            end

            ST_RESP: begin
                last_owner_d = attr_q.owner;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Response is steered to the owning port only.
        if (resp_en_c) begin
            if (attr_q.owner == OWN_DATA) begin
                data_valid_d = 1'b1;
                data_rdata_d = resp_data_c;
            end else begin
                inst_valid_d = 1'b1;
                inst_rdata_d = resp_data_c;
            end
        end
    end

    assign op_inst_valid    = inst_valid_q;
    assign op_inst_from_mem = inst_rdata_q;
    assign op_data_valid    = data_valid_q;
    assign op_data_from_mem = data_rdata_q;
    assign op_mem_req       = mem_req_q;
    assign op_mem_wr        = attr_q.wr;
    assign op_mem_addr      = addr_q;
    assign op_mem_mask      = attr_q.mask;
    assign op_mem_wdata     = attr_q.wdata;
    assign op_timeout       = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (MAX_WAIT = 4).
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int MAX_WAIT = 4;
    localparam logic INST = 1'b0;
    localparam logic DATA = 1'b1;

    logic          clk = 1'b0;
    logic          reset;
    logic          ip_inst_req;
    logic [AW-1:0] ip_inst_addr;
    logic          op_inst_valid;
    logic [31:0]   op_inst_from_mem;
    logic          ip_data_rd;
    logic          ip_data_wr;
    logic [AW-1:0] ip_data_addr;
    logic [3:0]    ip_data_mask;
    logic [31:0]   ip_data_from_proc;
    logic          op_data_valid;
    logic [31:0]   op_data_from_mem;
    logic          op_mem_req;
    logic          op_mem_wr;
    logic [AW-1:0] op_mem_addr;
    logic [3:0]    op_mem_mask;
    logic [31:0]   op_mem_wdata;
    logic          ip_mem_gnt;
    logic          ip_mem_rvalid;
    logic [31:0]   ip_mem_rdata;
    logic          op_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH (AW),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ip_inst_req       (ip_inst_req),
        .ip_inst_addr      (ip_inst_addr),
        .op_inst_valid     (op_inst_valid),
        .op_inst_from_mem  (op_inst_from_mem),
        .ip_data_rd        (ip_data_rd),
        .ip_data_wr        (ip_data_wr),
        .ip_data_addr      (ip_data_addr),
        .ip_data_mask      (ip_data_mask),
        .ip_data_from_proc (ip_data_from_proc),
        .op_data_valid     (op_data_valid),
        .op_data_from_mem  (op_data_from_mem),
        .op_mem_req        (op_mem_req),
        .op_mem_wr         (op_mem_wr),
        .op_mem_addr       (op_mem_addr),
        .op_mem_mask       (op_mem_mask),
        .op_mem_wdata      (op_mem_wdata),
        .ip_mem_gnt        (ip_mem_gnt),
        .ip_mem_rvalid     (ip_mem_rvalid),
        .ip_mem_rdata      (ip_mem_rdata),
        .op_timeout        (op_timeout)
    );

    // Count req/gnt handshakes seen by the memory.
    always @(posedge clk) begin
        if (op_mem_req && ip_mem_gnt) hs_cnt <= hs_cnt + 1;
    end

    typedef struct {
        logic        inst_req;
        logic [31:0] inst_addr;
        logic        data_rd;
        logic        data_wr;
        logic [31:0] data_addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        int          gnt_delay;   // cycles of ISSUE before gnt; -1 = never
        int          rv_delay;    // WAIT cycles before rvalid; -1 = never
        logic [31:0] rdata;
        logic        exp_owner;
        logic        exp_wr;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_resp;
        logic        exp_timeout;
    } vec_t;

    vec_t vecs[15];
    vec_t post_reset_vec;

    function automatic vec_t mkv(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [31:0] da, input logic [3:0] m, input logic [31:0] wd,
        input int gd, input int rd, input logic [31:0] rdat,
        input logic eo, input logic ew, input logic [31:0] ea, input logic [3:0] em,
        input logic [31:0] er, input logic et);
        vec_t v;
        v.inst_req = ir;  v.inst_addr = ia; v.data_rd = dr; v.data_wr = dw;
        v.data_addr = da; v.mask = m; v.wdata = wd; v.gnt_delay = gd; v.rv_delay = rd;
        v.rdata = rdat; v.exp_owner = eo; v.exp_wr = ew; v.exp_addr = ea;
        v.exp_mask = em; v.exp_resp = er; v.exp_timeout = et;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ip_inst_req = 1'b0; ip_inst_addr = '0;
        ip_data_rd = 1'b0; ip_data_wr = 1'b0; ip_data_addr = '0;
        ip_data_mask = '0; ip_data_from_proc = '0;
    endtask

    // Entered at a negedge with the DUT idle; leaves at a negedge with it idle.
    task automatic run_vec(input vec_t v, input int idx);
        int    base;
        int    n_issue;
        int    n_wait;
        string tag;
        base = hs_cnt;
        tag  = $sformatf("v%0d", idx);

        ip_inst_req       = v.inst_req;
        ip_inst_addr      = v.inst_addr;
        ip_data_rd        = v.data_rd;
        ip_data_wr        = v.data_wr;
        ip_data_addr      = v.data_addr;
        ip_data_mask      = v.mask;
        ip_data_from_proc = v.wdata;
        @(negedge clk);

        n_issue = (v.gnt_delay < 0) ? MAX_WAIT : v.gnt_delay + 1;
        for (int k = 0; k < n_issue; k++) begin
            check({tag, "_issue_req"},  32'(op_mem_req), 32'd1);
            check({tag, "_issue_wr"},   32'(op_mem_wr), 32'(v.exp_wr));
            check({tag, "_issue_addr"}, op_mem_addr, v.exp_addr);
            check({tag, "_issue_mask"}, 32'(op_mem_mask), 32'(v.exp_mask));
            if (v.exp_wr) check({tag, "_issue_wdata"}, op_mem_wdata, v.wdata);
            // Requesters wander while pending; the latched copy must be used.
            ip_inst_addr = ~v.inst_addr;
            ip_data_addr = ~v.data_addr;
            if (k == v.gnt_delay) ip_mem_gnt = 1'b1;
            @(negedge clk);
            ip_mem_gnt = 1'b0;
        end

        if ((v.gnt_delay >= 0) && !v.exp_wr) begin
            n_wait = (v.rv_delay < 0) ? (MAX_WAIT - 1 - v.gnt_delay) : v.rv_delay + 1;
            for (int k = 0; k < n_wait; k++) begin
                check({tag, "_wait_req"}, 32'(op_mem_req), 32'd0);
                check({tag, "_wait_ivalid"}, 32'(op_inst_valid), 32'd0);
                check({tag, "_wait_dvalid"}, 32'(op_data_valid), 32'd0);
                if (k == v.rv_delay) begin
                    ip_mem_rvalid = 1'b1;
                    ip_mem_rdata  = v.rdata;
                end
                @(negedge clk);
                ip_mem_rvalid = 1'b0;
                ip_mem_rdata  = 32'hBAD0_BAD0;
            end
        end

        check({tag, "_resp_req"},    32'(op_mem_req), 32'd0);
        check({tag, "_resp_ivalid"}, 32'(op_inst_valid), 32'(v.exp_owner == INST));
        check({tag, "_resp_dvalid"}, 32'(op_data_valid), 32'(v.exp_owner == DATA));
        if (v.exp_owner == DATA) check({tag, "_resp_ddata"}, op_data_from_mem, v.exp_resp);
        else                     check({tag, "_resp_idata"}, op_inst_from_mem, v.exp_resp);
        check({tag, "_timeout"},    32'(op_timeout), 32'(v.exp_timeout));
        check({tag, "_handshakes"}, 32'(hs_cnt - base), (v.gnt_delay >= 0) ? 32'd1 : 32'd0);

        clear_inputs();
        @(negedge clk);
        check({tag, "_pulse_ivalid"}, 32'(op_inst_valid), 32'd0);
        check({tag, "_pulse_dvalid"}, 32'(op_data_valid), 32'd0);
        check({tag, "_idle_req"},     32'(op_mem_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Lone fetch, then fetch+write contention, then back-to-back contention.
        vecs[0]  = mkv(1, 32'h10, 0, 0, 0, 4'h0, 0, 0, 0, 32'h0050_0093,
                       INST, 0, 32'h10, 4'hF, 32'h0050_0093, 0);
        vecs[1]  = mkv(1, 32'h20, 0, 1, 32'h40, 4'b0011, 32'hDEAD_BEEF, 0, 0, 0,
                       DATA, 1, 32'h40, 4'b0011, 32'h0, 0);
        vecs[2]  = mkv(1, 32'h20, 0, 0, 0, 4'h0, 0, 1, 0, 32'hA5A5_0001,
                       INST, 0, 32'h20, 4'hF, 32'hA5A5_0001, 0);
        for (int i = 0; i < 6; i++) begin
            vecs[3+i] = mkv(1, 32'h100 + 32'(4*i), 1, 0, 32'h200 + 32'(4*i), 4'b0110, 0,
                            0, 0, 32'h3000_0000 + 32'(i),
                            (i % 2 == 0) ? DATA : INST, 0,
                            (i % 2 == 0) ? 32'h200 + 32'(4*i) : 32'h100 + 32'(4*i),
                            4'hF, 32'h3000_0000 + 32'(i), 0);
        end
        // Grant at the last allowed ISSUE cycle, rvalid at the last allowed cycle.
        vecs[9]  = mkv(0, 0, 0, 1, 32'h300, 4'b1100, 32'hCAFE_F00D, 3, 0, 0,
                       DATA, 1, 32'h300, 4'b1100, 32'h0, 0);
        vecs[10] = mkv(1, 32'h304, 0, 0, 0, 4'h0, 0, 2, 0, 32'h0BAD_CAFE,
                       INST, 0, 32'h304, 4'hF, 32'h0BAD_CAFE, 0);
        // Timeouts in ISSUE and in WAIT; sticky flag survives a normal transaction.
        vecs[11] = mkv(0, 0, 1, 0, 32'h400, 4'h0, 0, -1, 0, 32'hFFFF_FFFF,
                       DATA, 0, 32'h400, 4'hF, 32'h0, 1);
        vecs[12] = mkv(1, 32'h44, 0, 0, 0, 4'h0, 0, 0, 0, 32'h1357_9BDF,
                       INST, 0, 32'h44, 4'hF, 32'h1357_9BDF, 1);
        vecs[13] = mkv(0, 0, 1, 0, 32'h404, 4'h0, 0, 0, -1, 32'hFFFF_FFFF,
                       DATA, 0, 32'h404, 4'hF, 32'h0, 1);
        // rd and wr together act as a write.
        vecs[14] = mkv(0, 0, 1, 1, 32'h408, 4'b0101, 32'h1234_5678, 0, 0, 0,
                       DATA, 1, 32'h408, 4'b0101, 32'h0, 1);
        post_reset_vec = mkv(1, 32'h90, 0, 1, 32'h94, 4'hF, 32'h55AA_55AA, 0, 0, 0,
                             DATA, 1, 32'h94, 4'hF, 32'h0, 0);

        reset = 1'b0;
        clear_inputs();
        ip_mem_gnt = 1'b0; ip_mem_rvalid = 1'b0; ip_mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(op_mem_req), 32'd0);
        check("rst_ivalid",  32'(op_inst_valid), 32'd0);
        check("rst_dvalid",  32'(op_data_valid), 32'd0);
        check("rst_timeout", 32'(op_timeout), 32'd0);
        check("rst_addr",    op_mem_addr, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_mem_req", 32'(op_mem_req), 32'd0);

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // Reset asserted while waiting for read data.
        ip_inst_req = 1'b1; ip_inst_addr = 32'h80;
        @(negedge clk);
        check("mr_issue_req", 32'(op_mem_req), 32'd1);
        ip_mem_gnt = 1'b1;
        @(negedge clk);
        ip_mem_gnt = 1'b0;
        check("mr_wait_req", 32'(op_mem_req), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("mr_rst_req",     32'(op_mem_req), 32'd0);
        check("mr_rst_timeout", 32'(op_timeout), 32'd0);
        check("mr_rst_addr",    op_mem_addr, 32'd0);
        check("mr_rst_mask",    32'(op_mem_mask), 32'd0);
        check("mr_rst_ivalid",  32'(op_inst_valid), 32'd0);
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        ip_mem_rvalid = 1'b1; ip_mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        ip_mem_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("mr_late_rvalid_ivalid", 32'(op_inst_valid), 32'd0);
            check("mr_late_rvalid_req",    32'(op_mem_req), 32'd0);
        end
        // Round-robin pointer is back to its reset value: data wins first.
        run_vec(post_reset_vec, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
